// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state machine states.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Byte-lane write enables for a legal (aligned) access of the given size.
  function automatic logic [3:0] lane_en(logic [2:0] size, logic [1:0] off);
    logic [3:0] en;
    case (size)
      HSIZE_BYTE: en = 4'b0001 << off;
      HSIZE_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      default:    en = 4'b1111;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Single-port word array: byte-lane write at the clock edge, asynchronous read.
module ahb_sram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [3:0][7:0] r_mem [DEPTH];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][b] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL_i,
  input  logic [1:0]             HTRANS_i,
  input  logic [2:0]             HBURST_i,
  input  logic [2:0]             HSIZE_i,
  input  logic                   HWRITE_i,
  input  logic [HADDR_WIDTH-1:0] HADDR_i,
  input  logic [HDATA_WIDTH-1:0] HWDATA_i,
  input  logic                   HREADY_i,
  output logic                   HREADYOUT_o,
  output logic [HDATA_WIDTH-1:0] HRDATA_o,
  output logic                   HRESP_o,
  output logic                   HEXOKAY_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  slv_state_e    r_state;
  logic [3:0]    r_cnt;
  logic          r_rdy;
  logic          r_resp;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_off;
  logic [2:0]    r_size;
  logic          r_write;

  logic          w_accept;
  logic          w_oor;
  logic          w_badsz;
  logic          w_err;
  logic          w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_accept = HSEL_i & HREADY_i & HTRANS_i[1];
  // Anything at or beyond the end of the array has nonzero upper address bits.
  assign w_oor    = |HADDR_i[HADDR_WIDTH-1:AW+2];
  assign w_badsz  = (HSIZE_i > HSIZE_WORD) ||
                    ((HSIZE_i == HSIZE_HALF) && HADDR_i[0]) ||
                    ((HSIZE_i == HSIZE_WORD) && (|HADDR_i[1:0]));
  assign w_err    = w_oor | w_badsz;

  // Burst type and the SEQ/NONSEQ distinction do not change SRAM behaviour.
  assign w_unused = ^{HBURST_i, HTRANS_i[0]};

  // Slave FSM: address-phase capture, wait countdown, two-cycle error.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdy   <= 1'b1;
      r_resp  <= HRESP_OKAY;
      r_idx   <= '0;
      r_off   <= 2'd0;
      r_size  <= 3'd0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= ST_DATA;
            r_rdy   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state <= ST_ERR2;
          r_rdy   <= 1'b1;
          r_resp  <= HRESP_ERROR;
        end
        default: begin
          if (w_accept) begin
            r_idx   <= HADDR_i[AW+1:2];
            r_off   <= HADDR_i[1:0];
            r_size  <= HSIZE_i;
            r_write <= HWRITE_i;
            if (w_err) begin
              r_state <= ST_ERR1;
              r_rdy   <= 1'b0;
              r_resp  <= HRESP_ERROR;
            end else if (WAIT_STATES != 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= 4'(WAIT_STATES);
              r_rdy   <= 1'b0;
              r_resp  <= HRESP_OKAY;
            end else begin
              r_state <= ST_DATA;
              r_rdy   <= 1'b1;
              r_resp  <= HRESP_OKAY;
            end
          end else begin
            r_state <= ST_IDLE;
            r_rdy   <= 1'b1;
            r_resp  <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Only an OKAY transfer reaches DATA, so error transfers never write.
  assign w_we = (r_state == ST_DATA) & r_write;

  ahb_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk     (HCLK),
    .i_we    (w_we),
    .i_be    (lane_en(r_size, r_off)),
    .i_idx   (r_idx),
    .i_wdata (HWDATA_i[31:0]),
    .o_rdata (w_rdata)
  );

  assign HREADYOUT_o = r_rdy;
  assign HRESP_o     = r_resp;
  assign HEXOKAY_o   = 1'b0;
  assign HRDATA_o    = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench: directed vector tables, reset-during-wait sequence, randomized traffic vs. a word model.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } xfer_t;

  typedef struct {
    xfer_t       x;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        sel = 1'b0;
  logic [1:0]  trans = 2'b00;
  logic [2:0]  burst = 3'd0;
  logic [2:0]  size = 3'd2;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  int          dsel = 0;

  logic        rdy0, resp0, exo0, rdy1, resp1, exo1;
  logic [31:0] rd0, rd1;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(8192), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_i(sel && dsel == 0), .HTRANS_i(trans),
    .HBURST_i(burst), .HSIZE_i(size), .HWRITE_i(wr), .HADDR_i(addr), .HWDATA_i(wdata),
    .HREADY_i(rdy0), .HREADYOUT_o(rdy0), .HRDATA_o(rd0), .HRESP_o(resp0), .HEXOKAY_o(exo0));

  ahb_sram_slave #(.HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_i(sel && dsel == 1), .HTRANS_i(trans),
    .HBURST_i(burst), .HSIZE_i(size), .HWRITE_i(wr), .HADDR_i(addr), .HWDATA_i(wdata),
    .HREADY_i(rdy1), .HREADYOUT_o(rdy1), .HRDATA_o(rd1), .HRESP_o(resp1), .HEXOKAY_o(exo1));

  int n_pass = 0;
  int n_tot  = 0;

  vec_t        tbl[$];
  int          res_waits[128];
  bit          res_resp[128];
  bit          res_lowresp[128];
  logic [31:0] res_rd[128];
  int          res_cycles;

  logic [31:0] mdl0[int];
  logic [31:0] mdl1[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  function automatic xfer_t mk(logic w, logic [31:0] a, logic [2:0] sz, logic [31:0] wd, logic [1:0] tr);
    xfer_t x;
    x.wr = w; x.addr = a; x.size = sz; x.wdata = wd; x.trans = tr;
    return x;
  endfunction

  task automatic addv(input xfer_t x, input bit err, input bit c, input logic [31:0] rd);
    vec_t v;
    v.x = x; v.err = err; v.chk_rd = c; v.rd = rd;
    tbl.push_back(v);
  endtask

  // Pipelined AHB master over the table contents; records each transfer's data-phase outcome.
  task automatic run(input int d);
    int ia = 0;
    int dp = -1;
    int cyc = 0;
    logic r, rs;
    logic [31:0] rdv;
    dsel = d;
    for (int i = 0; i < tbl.size(); i++) begin
      res_waits[i] = 0; res_resp[i] = 0; res_lowresp[i] = 0; res_rd[i] = '0;
    end
    while ((ia < tbl.size() || dp >= 0) && cyc < 2000) begin
      if (ia < tbl.size()) begin
        sel = 1'b1; trans = tbl[ia].x.trans; wr = tbl[ia].x.wr;
        addr = tbl[ia].x.addr; size = tbl[ia].x.size;
      end else begin
        sel = 1'b0; trans = 2'b00;
      end
      if (dp >= 0) wdata = tbl[dp].x.wdata;
      @(negedge HCLK);
      r = d ? rdy1 : rdy0; rs = d ? resp1 : resp0; rdv = d ? rd1 : rd0;
      if (dp >= 0) begin
        if (!r) begin
          res_waits[dp]++;
          if (rs) res_lowresp[dp] = 1'b1;
        end else begin
          res_resp[dp] = rs; res_rd[dp] = rdv;
        end
      end
      @(posedge HCLK); #1;
      cyc++;
      if (r) begin
        if (ia < tbl.size()) begin dp = ia; ia++; end
        else dp = -1;
      end
    end
    sel = 1'b0; trans = 2'b00;
    res_cycles = cyc;
    if (cyc >= 2000) begin
      n_tot++;
      $display("FAIL run_bound actual=%0d cycles required<2000", cyc);
    end
  endtask

  // Run the table on DUT d and compare every entry against its expectation.
  task automatic apply(input int d, input string tag);
    int ws = d ? 3 : 0;
    run(d);
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("%s[%0d].waits", tag, i), 32'(res_waits[i]), 32'(tbl[i].err ? 1 : ws));
      chk($sformatf("%s[%0d].resp", tag, i), 32'(res_resp[i]), 32'(tbl[i].err));
      chk($sformatf("%s[%0d].err1resp", tag, i), 32'(res_lowresp[i]), 32'(tbl[i].err));
      if (tbl[i].chk_rd) chk($sformatf("%s[%0d].rdata", tag, i), res_rd[i], tbl[i].rd);
    end
  endtask

  // Word-level reference: legality from the address/size rules, byte merge by offset.
  task automatic model_step(input int d, input xfer_t x, output bit err, output bit known,
                            output logic [31:0] rd);
    int unsigned depth = d ? 1024 : 8192;
    int wi = int'(x.addr >> 2);
    int off = int'(x.addr % 4);
    int nb;
    logic [31:0] w;
    bit have;
    err = (x.addr >= 4 * depth) || (x.size > 2) ||
          (x.size == 1 && x.addr % 2 != 0) || (x.size == 2 && off != 0);
    known = 1'b0; rd = '0;
    if (err) return;
    have = d ? mdl1.exists(wi) : mdl0.exists(wi);
    w = have ? (d ? mdl1[wi] : mdl0[wi]) : '0;
    if (x.wr) begin
      nb = 1 << x.size;
      for (int b = 0; b < nb; b++) w[(off + b) * 8 +: 8] = x.wdata[(off + b) * 8 +: 8];
      if (have || nb == 4) begin
        if (d != 0) mdl1[wi] = w; else mdl0[wi] = w;
      end
    end else begin
      known = have; rd = w;
    end
  endtask

  initial begin
    bit e, k;
    logic [31:0] m;
    xfer_t x;
    logic [31:0] a;
    logic [2:0] sz;

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst.hreadyout0", 32'(rdy0), 32'd1);
    chk("rst.hresp0", 32'(resp0), 32'd0);
    chk("rst.hrdata0", rd0, 32'd0);
    chk("rst.hexokay0", 32'(exo0), 32'd0);
    chk("rst.hreadyout1", 32'(rdy1), 32'd1);
    chk("rst.hrdata1", rd1, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Zero-wait DUT: word RAW, INCR4 burst, byte/half merge, misaligned halfword error.
    tbl = {};
    addv(mk(1, 32'h0, 3'd2, 32'hAFAFBFBF, 2'b10), 0, 0, 0);
    addv(mk(0, 32'h0, 3'd2, 32'h0, 2'b10), 0, 1, 32'hAFAFBFBF);
    addv(mk(1, 32'h6000, 3'd2, 32'h0000ABCD, 2'b10), 0, 0, 0);
    addv(mk(1, 32'h6004, 3'd2, 32'h00001111, 2'b11), 0, 0, 0);
    addv(mk(1, 32'h6008, 3'd2, 32'h00000002, 2'b11), 0, 0, 0);
    addv(mk(1, 32'h600C, 3'd2, 32'h00000088, 2'b11), 0, 0, 0);
    addv(mk(1, 32'h10, 3'd2, 32'h11223344, 2'b10), 0, 0, 0);
    addv(mk(1, 32'h12, 3'd0, 32'h00FF0000, 2'b10), 0, 0, 0);
    addv(mk(1, 32'h10, 3'd1, 32'h0000BEEF, 2'b10), 0, 0, 0);
    addv(mk(0, 32'h10, 3'd2, 32'h0, 2'b10), 0, 1, 32'h11FFBEEF);
    addv(mk(1, 32'h1, 3'd1, 32'hFFFFFFFF, 2'b10), 1, 0, 0);
    addv(mk(0, 32'h0, 3'd2, 32'h0, 2'b10), 0, 1, 32'hAFAFBFBF);
    apply(0, "dir0");

    // INCR4 read-back: four beats in consecutive cycles after the NONSEQ address cycle.
    tbl = {};
    burst = 3'd3;
    addv(mk(0, 32'h6000, 3'd2, 32'h0, 2'b10), 0, 1, 32'h0000ABCD);
    addv(mk(0, 32'h6004, 3'd2, 32'h0, 2'b11), 0, 1, 32'h00001111);
    addv(mk(0, 32'h6008, 3'd2, 32'h0, 2'b11), 0, 1, 32'h00000002);
    addv(mk(0, 32'h600C, 3'd2, 32'h0, 2'b11), 0, 1, 32'h00000088);
    apply(0, "incr4");
    chk("incr4.cycles", 32'(res_cycles), 32'd5);
    burst = 3'd0;

    // Three-wait DUT: waits, out-of-range read, misaligned half write leaves word intact.
    tbl = {};
    addv(mk(1, 32'h0, 3'd2, 32'h5A5A5A5A, 2'b10), 0, 0, 0);
    addv(mk(0, 32'h1000, 3'd2, 32'h0, 2'b10), 1, 0, 0);
    addv(mk(1, 32'h1, 3'd1, 32'hFFFFFFFF, 2'b10), 1, 0, 0);
    addv(mk(0, 32'h0, 3'd2, 32'h0, 2'b10), 0, 1, 32'h5A5A5A5A);
    addv(mk(1, 32'h40, 3'd2, 32'h12345678, 2'b10), 0, 0, 0);
    apply(1, "dir1");
    chk("dir1.hexokay", 32'(exo1), 32'd0);

    // Reset pulsed while a write sits in its wait states: write is abandoned.
    dsel = 1; sel = 1'b1; trans = 2'b10; wr = 1'b1; addr = 32'h40; size = 3'd2;
    @(posedge HCLK); #1;
    sel = 1'b0; trans = 2'b00; wdata = 32'hDEADBEEF;
    @(negedge HCLK);
    chk("rstwait.low", 32'(rdy1), 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rstwait.hreadyout", 32'(rdy1), 32'd1);
    chk("rstwait.hresp", 32'(resp1), 32'd0);
    chk("rstwait.hrdata", rd1, 32'd0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    tbl = {};
    addv(mk(0, 32'h40, 3'd2, 32'h0, 2'b10), 0, 1, 32'h12345678);
    apply(1, "rstwait");

    // Randomized traffic on both DUTs against the word model.
    for (int d = 0; d < 2; d++) begin
      tbl = {};
      for (int i = 0; i < 16; i++) begin
        x = mk(1, 32'h100 + 32'(i * 4), 3'd2, $urandom, 2'b10);
        model_step(d, x, e, k, m);
        addv(x, e, 0, 0);
      end
      for (int i = 0; i < 40; i++) begin
        sz = 3'($urandom_range(0, 3));
        a = 32'h100 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
        if ($urandom_range(0, 9) == 0) a = 32'h10000 + 32'($urandom_range(0, 255));
        x = mk(1'($urandom_range(0, 1)), a, sz, $urandom, 2'($urandom_range(2, 3)));
        model_step(d, x, e, k, m);
        addv(x, e, k && !x.wr, m);
      end
      apply(d, d ? "rnd1" : "rnd0");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
